// File: rtl/arbiter_rr_encoded.sv
// arbiter_rr_encoded: registered N-way arbiter for masters that share one
// resource. Each grant is presented as a one-hot vector and as a binary index,
// with a valid/ready handshake. A presented grant stays put until it is
// accepted. Round-robin (the default) or fixed priority is chosen by a
// parameter; in fixed priority the lowest index wins.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   req          per-channel request levels
//   grant_valid  a grant is being presented
//   grant_ready  consumer accepts the presented grant this cycle
//   grant_onehot one-hot grant, zero when grant_valid=0
//   grant_idx    binary index of the grant, zero when grant_valid=0
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no grant presented; waiting for any request
// HOLD  | grant registered and presented until grant_ready

module arbiter_rr_encoded #(
  parameter int N_REQ          = 8,
  parameter int W_IDX          = (N_REQ > 1 ? $clog2(N_REQ) : 1),
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [W_IDX-1:0] grant_idx
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // After reset channel 0 is first in line.
  localparam logic [W_IDX-1:0] PTR_RST = W_IDX'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [W_IDX-1:0] ptr_q, ptr_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] oh_q, oh_d;

  logic             accept;
  logic             any_req;
  logic [W_IDX-1:0] arb_ptr;
  logic [W_IDX-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;
  logic             hi_found;
  logic [W_IDX-1:0] hi_idx, lo_idx;
  logic [N_REQ-1:0] hi_oh, lo_oh;

  assign accept  = (state_q == HOLD) && grant_ready;
  assign any_req = |req;
  // On accept, re-arbitration in the same cycle already sees the channel just
  // granted as the last-granted one.
  assign arb_ptr = accept ? idx_q : ptr_q;

  // Scan from the top down so the last hit is the lowest set bit. The "hi"
  // search only considers channels strictly above the pointer; the plain
  // lowest requester is the fallback when nothing above the pointer asks.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_oh    = '0;
    lo_oh    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx    = W_IDX'(i);
        lo_oh     = '0;
        lo_oh[i]  = 1'b1;
        if (!FIXED_PRIORITY && (i > int'(arb_ptr))) begin
          hi_found = 1'b1;
          hi_idx   = W_IDX'(i);
          hi_oh    = '0;
          hi_oh[i] = 1'b1;
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    win_oh  = hi_found ? hi_oh  : lo_oh;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    if (accept) begin
      ptr_d = idx_q;
    end
    // While HOLD waits for ready, everything is frozen regardless of req.
    if ((state_q == IDLE) || accept) begin
      if (any_req) begin
        state_d = HOLD;
        idx_d   = win_idx;
        oh_d    = win_oh;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
        oh_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

  assign grant_valid  = (state_q == HOLD);
  assign grant_onehot = oh_q;
  assign grant_idx    = idx_q;

endmodule

// File: doc/arbiter_rr_encoded.md
Name: arbiter_rr_encoded

Overview:
- Registered N-way arbiter. Selects one requester per arbitration and presents the grant as one-hot and binary index, with a valid/ready handshake.
- Round-robin or fixed-priority mode, set by parameter.
- Sits between multiple bus/DMA masters and a shared resource.
- Replaces the separate combinational priority-filter-plus-encoder arrangement with one pipelined, fair block.

Parameters:
- N_REQ, 8, number of request channels (>=1)
- W_IDX, (N_REQ > 1 ? $clog2(N_REQ) : 1), width of binary grant index; leave at default
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = fixed priority, lowest index wins

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-channel request level
- grant_valid  output  1  a grant is being presented
- grant_ready  input  1  consumer accepts the presented grant this cycle
- grant_onehot  output  N_REQ  one-hot grant vector; all zero when grant_valid=0
- grant_idx  output  W_IDX  binary index of the granted channel; 0 when grant_valid=0

Behaviour:
- Single clock; reset is asynchronous and active-low (rst_n). Clock and reset are fixed as stated.
- Reset values:
  - grant_valid=0, grant_onehot=0, grant_idx=0.
  - Last-granted pointer = N_REQ-1, so channel 0 has top priority after reset.
- Two states:
  - IDLE: grant_valid=0.
  - HOLD: grant_valid=1.
- Winner function:
  - mask = bits strictly above last-granted index.
  - If (req & mask) != 0, winner = lowest set bit of (req & mask); otherwise winner = lowest set bit of req.
  - FIXED_PRIORITY=1: mask is treated as zero, so winner = lowest set bit of req.
- IDLE transitions:
  - |req=1 at edge n: register winner into grant_onehot/grant_idx; grant_valid=1 from cycle n+1. Latency is exactly one cycle; there is no combinational path from req to outputs.
  - |req=0: stay in IDLE.
- HOLD transitions:
  - grant_ready=0: grant_onehot, grant_idx, grant_valid and pointer all hold stable, even if req changes or the granted requester deasserts. The grant is never revoked.
  - grant_ready=1 at edge n: pointer <= grant_idx (used in round-robin mode only). Then re-arbitrate the same cycle using the updated mask:
    - |req=1: new grant registered at n+1, grant_valid stays 1. Throughput is one grant per cycle; with a continuously asserted requester the just-granted channel ranks lowest.
    - |req=0: go to IDLE; grant_valid=0 at n+1.
- grant_ready while grant_valid=0 is ignored.
- req at edge n is sampled regardless of its value at n-1; req is level-sensitive with no edge detection.
- Invariants:
  - grant_onehot has exactly one bit set whenever grant_valid=1.
  - grant_onehot[grant_idx]=1 whenever grant_valid=1.
  - Both are zero otherwise.
- N_REQ not a power of two: grant_idx never exceeds N_REQ-1; the pointer wraps from N_REQ-1 to 0.
- N_REQ=1: grant_idx is tied 0; behaviour reduces to a registered valid/ready slice of req[0].
- Reset asserted mid-HOLD: outputs clear immediately (asynchronous); the pointer returns to N_REQ-1. After deassertion the first grant goes to the lowest requesting index.

Test Plan:
- Reset, then req=8'b0000_0001 for one cycle, grant_ready=1 → cycle+1: grant_valid=1, grant_onehot=8'h01, grant_idx=0; cycle+2: grant_valid=0.
- RR mode, req=8'hFF held, grant_ready=1 → grant_idx sequence 0,1,2,...,7,0 on consecutive cycles, grant_valid continuously 1.
- RR mode, req=8'b1000_0100 held, grant_ready toggled 1,0,1,... → grants alternate 2,7,2,7; each grant stable through its ready=0 cycles.
- Backpressure: grant on idx 5, grant_ready=0 for 4 cycles while req changes to 8'h01 → idx 5 held all 4 cycles; after accept, next grant idx 0.
- FIXED_PRIORITY=1, req=8'b0110_0000 held, ready=1 → idx 5 every cycle; channel 6 starved (expected).
- N_REQ=5, req=5'b10001 held, ready=1 → idx 0,4,0,4 with pointer wrap; assert rst_n=0 mid-grant → grant_valid=0 immediately; after release first grant idx 0.
